// File: rtl/fp_shift_pkg.sv
// Shared definitions for the approximate-FP shifter blocks: FSM state
// encoding and helpers that derive stage count and shift-count width
// from the mantissa width.
package fp_shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Number of binary shift stages needed to cover a WIDTH-bit word.
  function automatic int stages_for(input int width);
    return $clog2(width);
  endfunction

  // A shift count must represent 0..WIDTH inclusive.
  function automatic int lz_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int DEFAULT_WIDTH = 32;
  localparam int LZ_W          = lz_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_norm_lshifter_norm_stage.sv
// Combinational single binary stage of the normalizing left shifter.
// Shifts the word left by 2^k when its top 2^k bits are all zero.
// With NORM_LIMIT_EN defined, the shift is also refused when it would
// push the accumulated count past the captured limit.
module norm_stage
  import fp_shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = stages_for(WIDTH),
  parameter int K_W    = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic [WIDTH-1:0]  data_i,
  input  logic [K_W-1:0]    k_i,
  input  logic [STAGES:0]   count_i,
`ifdef NORM_LIMIT_EN
  input  logic [STAGES:0]   limit_i,
`endif
  output logic [WIDTH-1:0]  data_o,
  output logic [STAGES:0]   count_o,
  output logic              take_o
);

  localparam int CW = STAGES + 1;

  logic [CW-1:0]    step;
  logic [WIDTH-1:0] lead_mask;
  logic             lead_zero;
`ifdef NORM_LIMIT_EN
  logic [CW:0]      sum_wide;
`endif

  // Decide whether this stage shifts, then produce the shifted word/count.
  always_comb begin
    step      = CW'(1) << k_i;
    lead_mask = ~({WIDTH{1'b1}} >> step);
    lead_zero = ((data_i & lead_mask) == '0);
`ifdef NORM_LIMIT_EN
    // Extra bit so count+step cannot wrap before the limit compare.
    sum_wide  = {1'b0, count_i} + {1'b0, step};
    take_o    = lead_zero && (sum_wide <= {1'b0, limit_i});
    count_o   = take_o ? sum_wide[CW-1:0] : count_i;
`else
    take_o    = lead_zero;
    count_o   = take_o ? (count_i + step) : count_i;
`endif
    data_o    = take_o ? (data_i << step) : data_i;
  end

endmodule

// File: rtl/seq_norm_lshifter.sv
// Multi-cycle normalizing logical left shifter. One binary stage
// (2^k, k = STAGES-1 down to 0) is evaluated per cycle, so the shifter
// is a single WIDTH-bit mux layer reused across cycles.
// Optional feature macro: NORM_LIMIT_EN (adds max_shift input that caps
// the applied shift, for denormal-style partial normalization).
//
// Handshake: a transfer happens on a rising clk edge where valid and
// ready are both high. in_ready is high only in IDLE; out_valid is high
// only in DONE and, once high, out/lz_count/zero stay stable until the
// transfer with out_ready. in_valid while busy is ignored; the source
// holds its word.
module seq_norm_lshifter
  import fp_shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = stages_for(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out,
  output logic [STAGES:0]   lz_count,
  output logic              zero,
`ifdef NORM_LIMIT_EN
  input  logic [STAGES:0]   max_shift,
`endif
  output logic [1:0]        dbg_state
);

  localparam int CW  = STAGES + 1;
  localparam int K_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  state_e           state_q;
  logic [WIDTH-1:0] work_q;
  logic [CW-1:0]    count_q;
  logic [K_W-1:0]   k_q;
  logic             src_zero_q;
  logic [WIDTH-1:0] out_q;
  logic [CW-1:0]    lz_q;
  logic             zero_q;
  logic             out_valid_q;
  logic             in_ready_q;
`ifdef NORM_LIMIT_EN
  logic [CW-1:0]    limit_q;
`endif

  logic [WIDTH-1:0] work_d;
  logic [CW-1:0]    count_d;
  logic             take_d;
  logic [CW-1:0]    lz_d;

  norm_stage #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .K_W    (K_W)
  ) u_stage (
    .data_i  (work_q),
    .k_i     (k_q),
    .count_i (count_q),
`ifdef NORM_LIMIT_EN
    .limit_i (limit_q),
`endif
    .data_o  (work_d),
    .count_o (count_d),
    .take_o  (take_d)
  );

  // Reported shift amount: an all-zero word reports the full width
  // (capped by the limit when present) rather than the raw stage sum.
  always_comb begin
    lz_d = count_q;
    if (src_zero_q) begin
`ifdef NORM_LIMIT_EN
      lz_d = (limit_q < CW'(WIDTH)) ? limit_q : CW'(WIDTH);
`else
      lz_d = CW'(WIDTH);
`endif
    end
  end

  // Control FSM with registered handshake and result outputs.
  // The result registers load on the first DONE cycle, so out_valid
  // rises STAGES+1 edges after the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      count_q     <= '0;
      k_q         <= '0;
      src_zero_q  <= 1'b0;
      out_q       <= '0;
      lz_q        <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef NORM_LIMIT_EN
      limit_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            work_q     <= in;
            count_q    <= '0;
            k_q        <= K_W'(STAGES - 1);
            src_zero_q <= (in == '0);
`ifdef NORM_LIMIT_EN
            limit_q    <= max_shift;
`endif
            in_ready_q <= 1'b0;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          work_q  <= work_d;
          count_q <= count_d;
          if (k_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            k_q <= k_q - K_W'(1);
          end
        end
        ST_DONE: begin
          if (!out_valid_q) begin
            out_q       <= work_q;
            lz_q        <= lz_d;
            zero_q      <= src_zero_q;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // take_d is internal to the stage decision; keep it observable for
  // debug alongside the state.
  logic take_unused;
  assign take_unused = take_d;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign lz_count  = lz_q;
  assign zero      = zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_norm_lshifter.sv
// Self-checking bench for seq_norm_lshifter: directed corner words,
// backpressure, reset during shifting, and random words against a
// leading-zero-count reference model. Also covers NORM_LIMIT_EN when
// the macro is defined.
module tb_seq_norm_lshifter;

  localparam int WIDTH  = 32;
  localparam int STAGES = 5;
  localparam int LW     = STAGES + 1;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [LW-1:0]     lz_count;
  logic              zero;
  logic [1:0]        dbg_state;
`ifdef NORM_LIMIT_EN
  logic [LW-1:0]     max_shift;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [LW-1:0]    exp_lz_q[$];
  logic             exp_zero_q[$];

  seq_norm_lshifter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_data),
    .lz_count  (lz_count),
    .zero      (zero),
`ifdef NORM_LIMIT_EN
    .max_shift (max_shift),
`endif
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: count leading zeros from the MSB.
  function automatic int lead_zeros(input logic [WIDTH-1:0] v);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) return WIDTH - 1 - i;
    end
    return WIDTH;
  endfunction

  function automatic int rand_lim();
`ifdef NORM_LIMIT_EN
    return $urandom_range(0, WIDTH);
`else
    return WIDTH;
`endif
  endfunction

  task automatic push_expected(input logic [WIDTH-1:0] data, input int lim);
    int sh;
    sh = lead_zeros(data);
    if (lim < sh) sh = lim;
    exp_q.push_back((data == '0) ? '0 : (data << sh));
    exp_lz_q.push_back(LW'(sh));
    exp_zero_q.push_back(data == '0);
  endtask

  task automatic wait_in_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  // Driver: one word through the block, with hold cycles of backpressure.
  task automatic run_word(input logic [WIDTH-1:0] data, input int lim, input int hold);
    int lat;
    logic [WIDTH-1:0] e_out;
    logic [LW-1:0]    e_lz;
    logic             e_zero;
    push_expected(data, lim);
    wait_in_ready();
    in_valid = 1'b1;
    in_data  = data;
`ifdef NORM_LIMIT_EN
    max_shift = LW'(lim);
`endif
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_in_ready", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", 64'(lat), 64'(STAGES + 1));
    e_out  = exp_q.pop_front();
    e_lz   = exp_lz_q.pop_front();
    e_zero = exp_zero_q.pop_front();
    check("out", 64'(out_data), 64'(e_out));
    check("lz_count", 64'(lz_count), 64'(e_lz));
    check("zero", 64'(zero), 64'(e_zero));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = ~data;
      @(posedge clk);
      @(negedge clk);
      check("hold_out", 64'(out_data), 64'(e_out));
      check("hold_lz", 64'(lz_count), 64'(e_lz));
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out"}, 64'(out_data), 64'd0);
    check({tag, "_lz"}, 64'(lz_count), 64'd0);
    check({tag, "_zero"}, 64'(zero), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
`ifdef NORM_LIMIT_EN
    max_shift = LW'(WIDTH);
`endif
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_word(32'h0000_0001, WIDTH, 0);
    run_word(32'h8000_0000, WIDTH, 0);
    run_word(32'h0000_0000, WIDTH, 0);
    run_word(32'h00F0_0000, WIDTH, 10);

    // Reset pulsed while shifting: no partial result, then normal operation.
    wait_in_ready();
    in_valid = 1'b1;
    in_data  = 32'h0000_FFFF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_word(32'h0000_FFFF, WIDTH, 0);

`ifdef NORM_LIMIT_EN
    run_word(32'h0000_0100, 10, 0);
    run_word(32'h0000_0100, 30, 0);
    run_word(32'h0000_0000, 7, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) d = '0;
      else d = WIDTH'($urandom) >> $urandom_range(0, WIDTH - 1);
      run_word(d, rand_lim(), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
